// File: rtl/calc_display_drv.sv
// Display driver for the 3-bit signed add/sub result.
// Captures a 4-bit sign-magnitude result {sign, mag[2:0]} on res_valid.
// Time-multiplexes two active-low 7-segment digits: the left digit shows
// the minus sign or blank, and the right digit shows the magnitude.
// Negative zero is normalised on capture, so "-0" is never displayed.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active low
//   res_valid  capture strobe for res
//   res        {sign, mag[2:0]} result
//   en         display enable, 0 = all digits dark
//   seg        segments {g,f,e,d,c,b,a}, active low, registered
//   an         anodes {left,right}, active low, registered
module calc_display_drv #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       res_valid,
   input  logic [3:0] res,
   input  logic       en,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [3:0]       res_q;
   logic [CNT_W-1:0] cnt;
   logic             dig;
   logic [6:0]       seg_c;
   logic [1:0]       an_c;

   // Magnitude digit to active-low segment pattern
   function automatic logic [6:0] digit_seg(input logic [2:0] d);
      logic [6:0] s;
      case (d)
         3'd0:    s = 7'b1000000;
         3'd1:    s = 7'b1111001;
         3'd2:    s = 7'b0100100;
         3'd3:    s = 7'b0110000;
         3'd4:    s = 7'b0011001;
         3'd5:    s = 7'b0010010;
         3'd6:    s = 7'b0000010;
         default: s = 7'b1111000;
      endcase
      return s;
   endfunction

   // Next output pattern from current digit phase, held result and enable
   always_comb begin
      seg_c = SEG_BLANK;
      an_c  = 2'b11;
      if (en) begin
         if (!dig) begin
            an_c  = 2'b10;
            seg_c = digit_seg(res_q[2:0]);
         end else begin
            an_c  = 2'b01;
            seg_c = res_q[3] ? SEG_MINUS : SEG_BLANK;
         end
      end
   end

   // Capture, refresh counter, digit phase and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q <= 4'b0000;
         cnt   <= '0;
         dig   <= 1'b0;
         seg   <= SEG_BLANK;
         an    <= 2'b11;
      end else begin
         // A zero magnitude always becomes +0
         if (res_valid) begin
            res_q <= (res[2:0] == 3'b000) ? 4'b0000 : res;
         end
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            dig <= ~dig;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         seg <= seg_c;
         an  <= an_c;
      end
   end

endmodule

// File: tb/tb_calc_display_drv.sv
// Directed bench for calc_display_drv with REFRESH_DIV=4.
// Edges after reset release are numbered 1,2,...; outputs after edge k show
// the right digit for k in 1..4, 9..12, ... and the left digit otherwise.
module tb_calc_display_drv;

   localparam logic [6:0] S0    = 7'b1000000;
   localparam logic [6:0] S3    = 7'b0110000;
   localparam logic [6:0] S5    = 7'b0010010;
   localparam logic [6:0] S7    = 7'b1111000;
   localparam logic [6:0] MINUS = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic       clk;
   logic       rst_n;
   logic       res_valid;
   logic [3:0] res;
   logic       en;
   logic [6:0] seg;
   logic [1:0] an;

   int n_tests = 0;
   int n_fail  = 0;

   calc_display_drv #(.REFRESH_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .res_valid (res_valid),
      .res       (res),
      .en        (en),
      .seg       (seg),
      .an        (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle on the falling edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_out(input string tag, input logic [1:0] exp_an, input logic [6:0] exp_seg);
      check({tag, ".an"},  8'(an),  8'(exp_an));
      check({tag, ".seg"}, 8'(seg), 8'(exp_seg));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; res_valid = 1'b0; res = 4'b0000;

      // 1: reset, then release
      tick(2);
      check_out("reset", 2'b11, BLANK);
      rst_n = 1'b1;
      tick(1);                                   // edge 1
      check_out("release", 2'b10, S0);

      // 2: -5
      res = 4'b1101; res_valid = 1'b1;
      tick(1);                                   // edge 2 capture
      res_valid = 1'b0;
      check_out("neg5_cap", 2'b10, S0);
      tick(1);                                   // edge 3
      check_out("neg5_right", 2'b10, S5);
      tick(1);                                   // edge 4
      check_out("neg5_right_last", 2'b10, S5);
      tick(1);                                   // edge 5
      check_out("neg5_left", 2'b01, MINUS);
      tick(3);                                   // edge 8

      // 3: +3
      res = 4'b0011; res_valid = 1'b1;
      tick(1);                                   // edge 9 capture
      res_valid = 1'b0;
      check_out("pos3_cap", 2'b10, S5);
      tick(1);                                   // edge 10
      check_out("pos3_right", 2'b10, S3);
      tick(2);                                   // edge 12
      check_out("pos3_right_last", 2'b10, S3);
      tick(1);                                   // edge 13
      check_out("pos3_left", 2'b01, BLANK);
      tick(3);                                   // edge 16
      check_out("pos3_left_last", 2'b01, BLANK);
      tick(1);                                   // edge 17
      check_out("pos3_wrap", 2'b10, S3);

      // 4: -0 normalises to +0
      res = 4'b1000; res_valid = 1'b1;
      tick(1);                                   // edge 18 capture
      res_valid = 1'b0;
      tick(1);                                   // edge 19
      check_out("negzero_right", 2'b10, S0);
      tick(2);                                   // edge 21
      check_out("negzero_left", 2'b01, BLANK);

      // 5: enable off mid-phase, then capture on the wrap edge
      en = 1'b0;
      tick(1);                                   // edge 22
      check_out("en_off", 2'b11, BLANK);
      tick(1);                                   // edge 23
      en = 1'b1;
      tick(1);                                   // edge 24, still left phase
      check_out("en_resume", 2'b01, BLANK);
      tick(1);                                   // edge 25
      check_out("en_phase", 2'b10, S0);
      tick(2);                                   // edge 27, cnt now 3
      res = 4'b1111; res_valid = 1'b1;
      tick(1);                                   // edge 28 capture + toggle
      res_valid = 1'b0;
      check_out("wrap_cap", 2'b10, S0);
      tick(1);                                   // edge 29
      check_out("wrap_left", 2'b01, MINUS);
      tick(4);                                   // edge 33
      check_out("neg7_right", 2'b10, S7);

      // 6: reset while showing -7
      rst_n = 1'b0;
      tick(1);                                   // edge 34
      check_out("mid_reset", 2'b11, BLANK);
      rst_n = 1'b1;
      tick(1);                                   // edge 1 after release
      check_out("post_reset", 2'b10, S0);
      tick(4);                                   // edge 5
      check_out("post_reset_left", 2'b01, BLANK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
